wb_cmd_master: RTL

Wishbone classic-cycle bus master driven by a command/stream front end. It accepts a command (start address, direction, byte selects, beat count), then runs that many single-word Wishbone transfers at incrementing addresses under one continuous `cyc_o`. Write data comes from an input stream, read data goes to an output stream, and a one-cycle status pulse reports the outcome. It is the initiator that drives memory-style Wishbone slaves such as `wb_ram` from a CPU-less control path or test harness.

---
 rtl/wb_cmd_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic-cycle burst master fed by a command port.
// One command runs cmd_len+1 single-word transfers at incrementing addresses
// under a single cyc_o. Write words come from the wr_* stream, read words go
// out on the rd_* stream, and a one-cycle status pulse reports the outcome.
module wb_cmd_master #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int LEN_WIDTH    = 8,
   parameter int TIMEOUT      = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic                    cmd_we,
   input  logic [SELECT_WIDTH-1:0] cmd_sel,
   input  logic [LEN_WIDTH-1:0]    cmd_len,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic                    sts_valid,
   output logic                    sts_err,
   output logic                    sts_timeout,
   output logic [LEN_WIDTH:0]      sts_count,
   output logic                    busy,
   output logic [ADDR_WIDTH-1:0]   adr_o,
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic                    we_o,
   output logic [SELECT_WIDTH-1:0] sel_o,
   output logic                    stb_o,
   output logic                    cyc_o,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   input  logic                    ack_i,
   input  logic                    err_i
);

   // Timeout counter is wide enough to hold TIMEOUT-1; a zero TIMEOUT disables it.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(SELECT_WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      WDATA,
      BUS,
      RDWAIT,
      DONE
   } state_t;

   state_t               state;
   logic [LEN_WIDTH-1:0] len_r;
   logic [LEN_WIDTH:0]   count;
   logic [TW-1:0]        tmo;
   logic                 last_beat;

   // Handshake readiness is decoded straight from the state register so the
   // command port stays closed while a read word is still waiting to drain.
   assign cmd_ready = (state == IDLE) && !rd_valid;
   assign wr_ready  = (state == WDATA);
   assign busy      = (state != IDLE);
   assign last_beat = (count == {1'b0, len_r});

   // Burst sequencer: owns every bus output, the read buffer and the status pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         len_r       <= '0;
         count       <= '0;
         tmo         <= '0;
         adr_o       <= '0;
         dat_o       <= '0;
         we_o        <= 1'b0;
         sel_o       <= '0;
         stb_o       <= 1'b0;
         cyc_o       <= 1'b0;
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         sts_valid   <= 1'b0;
         sts_err     <= 1'b0;
         sts_timeout <= 1'b0;
         sts_count   <= '0;
      end else begin
         sts_valid <= 1'b0;
         if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (cmd_valid && !rd_valid) begin
                  adr_o <= cmd_addr;
                  we_o  <= cmd_we;
                  sel_o <= cmd_sel;
                  len_r <= cmd_len;
                  count <= '0;
                  tmo   <= '0;
                  cyc_o <= 1'b1;
                  if (cmd_we) begin
                     state <= WDATA;
                  end else begin
                     stb_o <= 1'b1;
                     state <= BUS;
                  end
               end
            end
            WDATA: begin
               if (wr_valid) begin
                  dat_o <= wr_data;
                  stb_o <= 1'b1;
                  tmo   <= '0;
                  state <= BUS;
               end
            end
            BUS: begin
               if (err_i) begin
                  stb_o       <= 1'b0;
                  cyc_o       <= 1'b0;
                  sts_valid   <= 1'b1;
                  sts_err     <= 1'b1;
                  sts_timeout <= 1'b0;
                  sts_count   <= count;
                  state       <= DONE;
               end else if (ack_i) begin
                  stb_o <= 1'b0;
                  count <= count + 1'b1;
                  if (!we_o) begin
                     rd_data  <= dat_i;
                     rd_valid <= 1'b1;
                  end
                  if (last_beat) begin
                     cyc_o       <= 1'b0;
                     sts_valid   <= 1'b1;
                     sts_err     <= 1'b0;
                     sts_timeout <= 1'b0;
                     sts_count   <= count + 1'b1;
                     state       <= DONE;
                  end else begin
                     adr_o <= adr_o + ADDR_STEP;
                     state <= we_o ? WDATA : RDWAIT;
                  end
               end else if ((TIMEOUT != 0) && (tmo == TMO_LAST)) begin
                  stb_o       <= 1'b0;
                  cyc_o       <= 1'b0;
                  sts_valid   <= 1'b1;
                  sts_err     <= 1'b0;
                  sts_timeout <= 1'b1;
                  sts_count   <= count;
                  state       <= DONE;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            RDWAIT: begin
               if (!rd_valid || rd_ready) begin
                  stb_o <= 1'b1;
                  tmo   <= '0;
                  state <= BUS;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
